reg_cmd_engine: RTL and testbench

Fast-clock-domain command engine that turns a host byte stream (UART/USB FIFO side) into register accesses on a bank of dual-clock registers. It drives each register's per-bit write mask and a shared write value, and returns register readback as bytes. It sits directly upstream of the register bank: its mask/value outputs feed the registers' fast-side write inputs, and their fast-side outputs feed its readback input.

---
 rtl/reg_cmd_engine_if.sv | 27 ++
 rtl/reg_cmd_engine.sv | 208 ++++++++++++++++++++
 tb/tb_reg_cmd_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_engine_if.sv
// Byte-stream handshake between the host FIFO side and the register command engine.
interface reg_cmd_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );
endinterface

// File: rtl/reg_cmd_engine.sv
// Turns a host byte stream into masked register writes and byte-wise readback
// for a bank of NREGS registers of WIDTH bits.
module reg_cmd_engine #(
  parameter int NREGS = 4,
  parameter int WIDTH = 16
) (
  input  logic                   fclk,
  input  logic                   frst_n,
  reg_cmd_engine_if.slave        bus,
  output logic [NREGS*WIDTH-1:0] reg_mask,
  output logic [WIDTH-1:0]       reg_wdata,
  input  logic [NREGS*WIDTH-1:0] reg_rdata,
  output logic                   err
);
  localparam int            NB        = WIDTH / 8;
  localparam int            CW        = (NB > 1) ? $clog2(NB) : 1;
  localparam int            TOP_SH    = WIDTH - 8;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  localparam logic [6:0]    NREGS_A   = 7'(NREGS);
  localparam logic [6:0]    STATUS_A  = 7'h7F;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    WMASK  = 3'd2,
    APPLY  = 3'd3,
    RSEND  = 3'd4,
    STATUS = 3'd5
  } state_t;

  state_t                   state_r;
  logic                     cmd_m_r;
  logic [6:0]               addr_r;
  logic [CW-1:0]            cnt_r;
  logic [WIDTH-1:0]         wdata_hold_r;
  logic [WIDTH-1:0]         mask_hold_r;
  logic [WIDTH-1:0]         snap_r;
  logic                     rx_ready_r;
  logic                     tx_valid_r;
  logic [7:0]               tx_data_r;
  logic [NREGS*WIDTH-1:0]   reg_mask_r;
  logic [WIDTH-1:0]         reg_wdata_r;
  logic                     err_r;

  logic                     rx_fire_s;
  logic                     tx_fire_s;
  logic [WIDTH-1:0]         wshift_s;
  logic [WIDTH-1:0]         mshift_s;
  logic [WIDTH-1:0]         snap_next_s;
  logic [WIDTH-1:0]         rd_sel_s;
  logic                     rd_hit_s;
  logic                     addr_miss_s;

  // Places mask m into slice a; out-of-range addresses drive no slice.
  function automatic logic [NREGS*WIDTH-1:0] spread_mask(input logic [6:0] a,
                                                         input logic [WIDTH-1:0] m);
    logic [NREGS*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) begin
      v[i*WIDTH +: WIDTH] = (a == 7'(i)) ? m : {WIDTH{1'b0}};
    end
    return v;
  endfunction

  // Selects slice a of the readback bus; a miss reads as all-ones.
  function automatic logic [WIDTH-1:0] pick_slice(input logic [6:0] a,
                                                  input logic [NREGS*WIDTH-1:0] bank);
    logic [WIDTH-1:0] s;
    s = {WIDTH{1'b1}};
    for (int i = 0; i < NREGS; i++) begin
      s = (a == 7'(i)) ? bank[i*WIDTH +: WIDTH] : s;
    end
    return s;
  endfunction

  assign rx_fire_s   = bus.rx_valid & rx_ready_r;
  assign tx_fire_s   = tx_valid_r & bus.tx_ready;
  // Little-endian assembly: each new byte enters at the top and shifts down.
  assign wshift_s    = (wdata_hold_r >> 8) | (WIDTH'(bus.rx_data) << TOP_SH);
  assign mshift_s    = (mask_hold_r >> 8) | (WIDTH'(bus.rx_data) << TOP_SH);
  assign snap_next_s = snap_r >> 8;
  assign rd_sel_s    = pick_slice(bus.rx_data[6:0], reg_rdata);
  assign rd_hit_s    = (bus.rx_data[6:0] < NREGS_A);
  assign addr_miss_s = (addr_r >= NREGS_A);

  // Command decode, byte assembly, write strobe and response sequencing.
  always_ff @(posedge fclk or negedge frst_n) begin
    if (!frst_n) begin
      state_r      <= IDLE;
      cmd_m_r      <= 1'b0;
      addr_r       <= 7'd0;
      cnt_r        <= '0;
      wdata_hold_r <= '0;
      mask_hold_r  <= '0;
      snap_r       <= '0;
      rx_ready_r   <= 1'b0;
      tx_valid_r   <= 1'b0;
      tx_data_r    <= 8'd0;
      reg_mask_r   <= '0;
      reg_wdata_r  <= '0;
      err_r        <= 1'b0;
    end else begin
      reg_mask_r <= '0;
      case (state_r)
        IDLE: begin
          rx_ready_r <= 1'b1;
          cnt_r      <= '0;
          if (rx_fire_s) begin
            cmd_m_r <= bus.rx_data[6];
            if (bus.rx_data[7]) begin
              addr_r  <= {1'b0, bus.rx_data[5:0]};
              state_r <= WDATA;
            end else if (bus.rx_data[6:0] == STATUS_A) begin
              rx_ready_r <= 1'b0;
              tx_valid_r <= 1'b1;
              tx_data_r  <= {7'd0, err_r};
              state_r    <= STATUS;
            end else begin
              rx_ready_r <= 1'b0;
              tx_valid_r <= 1'b1;
              snap_r     <= rd_sel_s;
              tx_data_r  <= rd_sel_s[7:0];
              state_r    <= RSEND;
              if (!rd_hit_s) begin
                err_r <= 1'b1;
              end
            end
          end
        end
        WDATA: begin
          if (rx_fire_s) begin
            wdata_hold_r <= wshift_s;
            if (cnt_r == LAST_BYTE) begin
              cnt_r <= '0;
              if (cmd_m_r) begin
                state_r <= WMASK;
              end else begin
                reg_wdata_r <= wshift_s;
                reg_mask_r  <= spread_mask(addr_r, {WIDTH{1'b1}});
                err_r       <= err_r | addr_miss_s;
                rx_ready_r  <= 1'b0;
                state_r     <= APPLY;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        WMASK: begin
          if (rx_fire_s) begin
            mask_hold_r <= mshift_s;
            if (cnt_r == LAST_BYTE) begin
              cnt_r       <= '0;
              reg_wdata_r <= wdata_hold_r;
              reg_mask_r  <= spread_mask(addr_r, mshift_s);
              err_r       <= err_r | addr_miss_s;
              rx_ready_r  <= 1'b0;
              state_r     <= APPLY;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        APPLY: begin
          rx_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
        RSEND: begin
          if (tx_fire_s) begin
            if (cnt_r == LAST_BYTE) begin
              cnt_r      <= '0;
              tx_valid_r <= 1'b0;
              tx_data_r  <= 8'd0;
              rx_ready_r <= 1'b1;
              state_r    <= IDLE;
            end else begin
              cnt_r     <= cnt_r + CW'(1);
              snap_r    <= snap_next_s;
              tx_data_r <= snap_next_s[7:0];
            end
          end
        end
        STATUS: begin
          if (tx_fire_s) begin
            err_r      <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'd0;
            rx_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        default: begin
          rx_ready_r <= 1'b0;
          tx_valid_r <= 1'b0;
          tx_data_r  <= 8'd0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ready = rx_ready_r;
  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_data  = tx_data_r;
  assign reg_mask     = reg_mask_r;
  assign reg_wdata    = reg_wdata_r;
  assign err          = err_r;
endmodule

// File: tb/tb_reg_cmd_engine.sv
// Self-checking bench for reg_cmd_engine: expected strobes and response bytes
// are queued when commands are driven and compared when the engine produces them.
module tb_reg_cmd_engine;
  localparam int NREGS = 4;
  localparam int WIDTH = 16;

  logic                   fclk = 1'b0;
  logic                   frst_n = 1'b0;
  logic [NREGS*WIDTH-1:0] reg_mask;
  logic [NREGS*WIDTH-1:0] reg_rdata;
  logic [WIDTH-1:0]       reg_wdata;
  logic                   err;

  reg_cmd_engine_if bus ();

  reg_cmd_engine #(.NREGS(NREGS), .WIDTH(WIDTH)) dut (
    .fclk     (fclk),
    .frst_n   (frst_n),
    .bus      (bus),
    .reg_mask (reg_mask),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .err      (err)
  );

  always #5 fclk = ~fclk;

  typedef struct packed {
    logic [NREGS*WIDTH-1:0] mask;
    logic [WIDTH-1:0]       wdata;
  } strobe_t;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] tx_q[$];
  strobe_t    strobe_q[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic monitor();
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    logic [7:0] e;
    strobe_t    s;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge fclk);
      if (frst_n) begin
        if (bus.tx_valid && bus.tx_ready) begin
          checks++;
          if (tx_q.size() == 0) begin
            fails++;
            $display("FAIL tx_unexpected: got %02h, no byte expected", bus.tx_data);
          end else begin
            e = tx_q.pop_front();
            if (bus.tx_data !== e) begin
              fails++;
              $display("FAIL tx_byte: got %02h, expected %02h", bus.tx_data, e);
            end
          end
        end
        if (!bus.tx_valid) begin
          checks++;
          if (bus.tx_data !== 8'h00) begin
            fails++;
            $display("FAIL tx_idle_zero: got %02h, expected 00", bus.tx_data);
          end
        end
        if (pv && !pr && bus.tx_valid) begin
          checks++;
          if (bus.tx_data !== pd) begin
            fails++;
            $display("FAIL tx_stall_stable: got %02h, expected %02h", bus.tx_data, pd);
          end
        end
        if (reg_mask !== '0) begin
          checks++;
          if (strobe_q.size() == 0) begin
            fails++;
            $display("FAIL strobe_unexpected: mask %016h, none expected", reg_mask);
          end else begin
            s = strobe_q.pop_front();
            if (reg_mask !== s.mask || reg_wdata !== s.wdata) begin
              fails++;
              $display("FAIL strobe: got mask %016h wdata %04h, expected mask %016h wdata %04h",
                       reg_mask, reg_wdata, s.mask, s.wdata);
            end
          end
        end
        pv = bus.tx_valid; pr = bus.tx_ready; pd = bus.tx_data;
      end else begin
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge fclk); #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge fclk);
      if (bus.rx_ready === 1'b1) break;
      n++;
      if (n > 100) begin
        checks++; fails++;
        $display("FAIL rx_accept_timeout: byte %02h not accepted", b);
        break;
      end
    end
    @(posedge fclk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic drain_tx();
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 200) begin
      @(negedge fclk); #1;
      checks++;
      if (bus.rx_ready !== 1'b0) begin
        fails++;
        $display("FAIL rx_ready_during_tx: got %b, expected 0", bus.rx_ready);
      end
      n++;
    end
    if (n >= 200) begin
      checks++; fails++;
      $display("FAIL tx_timeout: %0d bytes still pending", tx_q.size());
    end
    @(posedge fclk); #1;
    checks++;
    if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_tx_idle: rx_ready %b tx_valid %b, expected 1 0", bus.rx_ready, bus.tx_valid);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic m, input logic [15:0] d,
                          input logic [15:0] mk, input int maxgap);
    strobe_t                s;
    logic [NREGS*WIDTH-1:0] exp_mask;
    logic                   hit;
    hit = (int'(a) < NREGS);
    exp_mask = '0;
    if (hit) begin
      exp_mask[a*WIDTH +: WIDTH] = m ? mk : 16'hFFFF;
      s.mask = exp_mask; s.wdata = d;
      strobe_q.push_back(s);
    end
    send_byte({1'b1, m, a}, $urandom_range(0, maxgap));
    send_byte(d[7:0], $urandom_range(0, maxgap));
    send_byte(d[15:8], $urandom_range(0, maxgap));
    if (m) begin
      send_byte(mk[7:0], $urandom_range(0, maxgap));
      send_byte(mk[15:8], $urandom_range(0, maxgap));
    end
    checks++;
    if (reg_mask !== exp_mask) begin
      fails++;
      $display("FAIL apply_mask: got %016h, expected %016h", reg_mask, exp_mask);
    end
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL apply_rx_ready: got %b, expected 0", bus.rx_ready);
    end
    if (!hit) begin
      checks++;
      if (err !== 1'b1) begin
        fails++;
        $display("FAIL write_err: got %b, expected 1", err);
      end
    end
    @(posedge fclk); #1;
    checks++;
    if (reg_mask !== '0 || bus.rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL after_apply: mask %016h rx_ready %b, expected 0 1", reg_mask, bus.rx_ready);
    end
  endtask

  task automatic do_read(input logic [6:0] a, input int gap);
    logic [15:0] v;
    if (int'(a) < NREGS) v = reg_rdata[a*WIDTH +: WIDTH];
    else v = 16'hFFFF;
    tx_q.push_back(v[7:0]);
    tx_q.push_back(v[15:8]);
    send_byte({1'b0, a}, gap);
    if (int'(a) < NREGS) reg_rdata[a*WIDTH +: WIDTH] = ~v;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge fclk);
    #1;
    checks++;
    if (reg_mask !== '0 || reg_wdata !== '0 || err !== 1'b0 || bus.rx_ready !== 1'b0 ||
        bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: mask %016h wdata %04h err %b rx_ready %b tx_valid %b tx_data %02h, expected all 0",
               reg_mask, reg_wdata, err, bus.rx_ready, bus.tx_valid, bus.tx_data);
    end
    frst_n = 1'b1;
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL rx_ready_before_edge: got %b, expected 0", bus.rx_ready);
    end
    @(posedge fclk); #1;
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL rx_ready_first_edge: got %b, expected 1", bus.rx_ready);
    end
  endtask

  task automatic test_write();
    do_write(6'd2, 1'b0, 16'h1234, 16'h0000, 0);
  endtask

  task automatic test_masked_write();
    do_write(6'd1, 1'b1, 16'hABCD, 16'h0FF0, 0);
    do_write(6'd3, 1'b1, 16'h5A5A, 16'hFF00, 2);
  endtask

  task automatic test_read_stall();
    reg_rdata[3*WIDTH +: WIDTH] = 16'hBEEF;
    bus.tx_ready = 1'b0;
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'hBE);
    send_byte(8'h03, 0);
    reg_rdata[3*WIDTH +: WIDTH] = 16'h0000;
    repeat (3) begin
      @(negedge fclk); #1;
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hEF || bus.rx_ready !== 1'b0) begin
        fails++;
        $display("FAIL read_stall: tx_valid %b tx_data %02h rx_ready %b, expected 1 ef 0",
                 bus.tx_valid, bus.tx_data, bus.rx_ready);
      end
    end
    @(posedge fclk); #1;
    bus.tx_ready = 1'b1;
    drain_tx();
  endtask

  task automatic test_errors();
    do_write(6'd5, 1'b0, 16'h2211, 16'h0000, 0);
    tx_q.push_back(8'h01);
    send_byte(8'h7F, 0);
    drain_tx();
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL status_clears_err: got %b, expected 0", err);
    end
    tx_q.push_back(8'h00);
    send_byte(8'h7F, 1);
    drain_tx();
    do_read(7'h06, 0);
    drain_tx();
    checks++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL read_err: got %b, expected 1", err);
    end
  endtask

  task automatic test_reset_mid_command();
    send_byte(8'h80, 0);
    send_byte(8'h55, 0);
    frst_n = 1'b0;
    #1;
    checks++;
    if (reg_mask !== '0 || reg_wdata !== '0 || err !== 1'b0 || bus.rx_ready !== 1'b0 ||
        bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      fails++;
      $display("FAIL midcmd_reset: mask %016h wdata %04h err %b rx_ready %b, expected all 0",
               reg_mask, reg_wdata, err, bus.rx_ready);
    end
    @(posedge fclk); #1;
    frst_n = 1'b1;
    @(posedge fclk); #1;
    do_write(6'd0, 1'b0, 16'h7766, 16'h0000, 0);
  endtask

  task automatic test_back_to_back();
    strobe_t     s;
    logic [15:0] d;
    for (int it = 0; it < 4; it++) begin
      d = 16'($urandom);
      reg_rdata[15:0] = 16'($urandom);
      s.mask = '0;
      s.mask[15:0] = 16'hFFFF;
      s.wdata = d;
      strobe_q.push_back(s);
      send_byte(8'h80, $urandom_range(0, 3));
      send_byte(d[7:0], $urandom_range(0, 3));
      send_byte(d[15:8], $urandom_range(0, 3));
      do_read(7'h00, $urandom_range(0, 3));
      drain_tx();
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    reg_rdata    = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_write();
    test_masked_write();
    test_read_stall();
    test_errors();
    test_reset_mid_command();
    test_back_to_back();
    repeat (5) @(posedge fclk);
    #1;
    checks++;
    if (tx_q.size() != 0 || strobe_q.size() != 0) begin
      fails++;
      $display("FAIL queues_empty: tx %0d strobe %0d pending, expected 0 0", tx_q.size(), strobe_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
